jtag_scan_ctrl: RTL
===================

JTAG_SCAN_CTRL -- requirements
Module: jtag_scan_ctrl

Interface
REQ-001 SHALL have parameter C_IDLE_TCKS, default 1, number of extra TCKs spent in Run-Test/Idle after Update (range 0..29).
REQ-002 SHALL have port CLK  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port RESETN  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports CMD_VALID in 1, CMD_READY out 1: command handshake.
REQ-005 SHALL have ports CMD_IR in 1 (1 = IR scan, 0 = DR scan), CMD_LEN in 7 (bit count), CMD_TDI in 64 (LSB shifted first).
REQ-006 SHALL have ports RSP_VALID out 1, RSP_READY in 1, RSP_TDO out 64, RSP_ERR out 1: response handshake.
REQ-007 SHALL have shifter ports PROC_ENABLE out 1, PROC_LENGTH out 32, PROC_TMS out 32, PROC_TDI out 32, PROC_DONE in 1, PROC_TDO in 32 (bit k = TDO of k-th shifted bit).

Function
REQ-008 SHALL assert CMD_READY only in IDLE; a command is accepted on CMD_VALID && CMD_READY and all CMD_* fields are latched that cycle.
REQ-009 SHALL treat CMD_LEN == 0 or CMD_LEN > 64 as an error: no PROC_ENABLE, RSP_VALID=1, RSP_ERR=1, RSP_TDO=0 on the cycle after acceptance.
REQ-010 SHALL sequence a valid command as the shifter transactions PRE, D0, D1 (only if CMD_LEN > 32), POST, in that order.
REQ-011 PRE SHALL be: DR: length 3, TMS 0x1; IR: length 4, TMS 0x3; TDI 0 (Idle -> Shift-xR).
REQ-012 D0 SHALL be: length min(CMD_LEN,32), TDI CMD_TDI[31:0]; D1: length CMD_LEN-32, TDI CMD_TDI[63:32].
REQ-013 TMS in D0/D1 SHALL be 0 except bit (length-1) of the final data transaction, which SHALL be 1 (Exit1-xR).
REQ-014 POST SHALL be: length 2+C_IDLE_TCKS, TMS 0x1, TDI 0 (Update -> Idle).
REQ-015 Per transaction: one GO cycle with PROC_ENABLE=1, then WAIT with PROC_ENABLE=0 until PROC_DONE=1; the next GO SHALL be no earlier than the cycle after PROC_DONE.
REQ-016 PROC_LENGTH/PROC_TMS/PROC_TDI SHALL be registered, valid in the GO cycle, and held unchanged through WAIT.
REQ-017 On PROC_DONE of D0, SHALL store PROC_TDO[len0-1:0] into RSP_TDO[len0-1:0]; on D1 into RSP_TDO[CMD_LEN-1:32]; unshifted bits SHALL be 0.
REQ-018 After POST completes, SHALL assert RSP_VALID, RSP_ERR=0; RSP_VALID/RSP_TDO/RSP_ERR SHALL stay stable until RSP_READY=1, then return to IDLE next cycle.
REQ-019 PROC_DONE outside a WAIT state SHALL be ignored.
REQ-020 States: [TLR_GO, TLR_WAIT,] IDLE, PRE_GO, PRE_WAIT, D0_GO, D0_WAIT, D1_GO, D1_WAIT, POST_GO, POST_WAIT, RSP; no other transitions.

Reset
REQ-021 RESETN low SHALL immediately force: state to reset state, CMD_READY=0, RSP_VALID=0, RSP_ERR=0, RSP_TDO=0, PROC_ENABLE=0, PROC_LENGTH/TMS/TDI=0.
REQ-022 Reset mid-scan SHALL abandon the scan with no response; TAP state is then undefined unless REQ-024 applies.
REQ-023 Without macro, reset state SHALL be IDLE, CMD_READY=1 on the first clock after RESETN deasserts.

Configuration
REQ-024 With JTAG_SCAN_TLR_EN defined: reset state SHALL be TLR_GO, issuing one transaction length 6, TMS 0x1F, TDI 0 (Test-Logic-Reset -> Idle) before entering IDLE; without it, TLR states SHALL not exist.

Verification
REQ-025 DR, LEN 8, TDI 0xA5, C_IDLE_TCKS 1, mock TDO 0x3C -> transactions (3,0x1,0),(8,0x80,0xA5),(3,0x1,0); RSP_TDO 0x3C, ERR 0.
REQ-026 IR, LEN 40, TDI 0x12_3456789A -> (4,0x3,0),(32,0x0,0x3456789A),(8,0x80,0x12),(3,0x1,0); RSP_TDO = {D1 TDO[7:0], D0 TDO}.
REQ-027 DR, LEN 32 -> no D1; D0 TMS 0x80000000.
REQ-028 LEN 0 and LEN 65 -> RSP_VALID with ERR 1, TDO 0 one cycle after accept; PROC_ENABLE never high.
REQ-029 RSP_READY low 10 cycles -> RSP fields stable, CMD_READY 0, CMD_VALID ignored; READY high -> CMD_READY 1 next cycle.
REQ-030 RESETN low in D0_WAIT -> outputs per REQ-021 same cycle; with JTAG_SCAN_TLR_EN first transaction after release is (6,0x1F,0).

Source files
------------

// File: rtl/jtag_scan_ctrl.sv
// jtag_scan_ctrl: turns one IR/DR scan command into a short series of
// transactions for an external TMS/TDI shifter (PRE, D0, [D1], POST) and
// gathers the captured TDO bits into a single 64-bit response.
// Optional feature: define JTAG_SCAN_TLR_EN to walk the TAP through
// Test-Logic-Reset -> Run-Test/Idle once after every reset.
//
// Handshakes: a transfer happens on any rising CLK edge where valid and ready
// are both high. CMD_READY is high only in IDLE. RSP_VALID stays high, with
// RSP_TDO and RSP_ERR held, until the edge where RSP_READY is seen high.
module jtag_scan_ctrl #(
    parameter int C_IDLE_TCKS = 1
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_IR,
    input  logic [6:0]  CMD_LEN,
    input  logic [63:0] CMD_TDI,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [63:0] RSP_TDO,
    output logic        RSP_ERR,
    output logic        PROC_ENABLE,
    output logic [31:0] PROC_LENGTH,
    output logic [31:0] PROC_TMS,
    output logic [31:0] PROC_TDI,
    input  logic        PROC_DONE,
    input  logic [31:0] PROC_TDO,
    output logic [3:0]  o_dbg_state
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE_GO,
        ST_PRE_WAIT,
        ST_D0_GO,
        ST_D0_WAIT,
        ST_D1_GO,
        ST_D1_WAIT,
        ST_POST_GO,
        ST_POST_WAIT,
        ST_RSP
`ifdef JTAG_SCAN_TLR_EN
        ,
        ST_TLR_GO,
        ST_TLR_WAIT
`endif
    } state_t;

`ifdef JTAG_SCAN_TLR_EN
    localparam state_t LP_RESET_STATE = ST_TLR_GO;
`else
    localparam state_t LP_RESET_STATE = ST_IDLE;
`endif

    localparam logic [31:0] LP_POST_LEN = 32'(2 + C_IDLE_TCKS);

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [63:0] r_rsp_tdo;
    logic        r_proc_en;
    logic [31:0] r_proc_len;
    logic [31:0] r_proc_tms;
    logic [31:0] r_proc_tdi;
    logic        r_ir;
    logic [6:0]  r_len;
    logic [63:0] r_tdi;

    logic        w_has_d1;
    logic [5:0]  w_len0;
    logic [5:0]  w_len1;
    logic [31:0] w_tms0;
    logic [31:0] w_tms1;
    logic [31:0] w_mask0;
    logic [31:0] w_mask1;

    // Low n bits set (n = 1..32); used to clear TDO bits that were never shifted.
    function automatic logic [31:0] f_mask(input logic [5:0] n);
        f_mask = (n == 6'd0) ? 32'd0 : (32'hFFFF_FFFF >> (6'd32 - n));
    endfunction

    // Single bit at position n-1: the TMS bit that leaves Shift-xR.
    function automatic logic [31:0] f_last(input logic [5:0] n);
        f_last = (n == 6'd0) ? 32'd0 : (32'd1 << (n - 6'd1));
    endfunction

    // Split the latched length into the two data chunks. For 33..64 the low
    // six bits minus 32 wrap correctly (64 -> 0 - 32 = 32).
    always_comb begin
        w_has_d1 = (r_len > 7'd32);
        w_len0   = w_has_d1 ? 6'd32 : r_len[5:0];
        w_len1   = r_len[5:0] - 6'd32;
        w_tms0   = w_has_d1 ? 32'd0 : f_last(w_len0);
        w_tms1   = f_last(w_len1);
        w_mask0  = f_mask(w_len0);
        w_mask1  = f_mask(w_len1);
    end

    // Scan sequencer: every GO state holds PROC_ENABLE for exactly one cycle,
    // every WAIT state loads the next transaction when PROC_DONE arrives.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state     <= LP_RESET_STATE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_tdo   <= 64'd0;
            r_proc_en   <= 1'b0;
            r_proc_len  <= 32'd0;
            r_proc_tms  <= 32'd0;
            r_proc_tdi  <= 32'd0;
            r_ir        <= 1'b0;
            r_len       <= 7'd0;
            r_tdi       <= 64'd0;
        end else begin
            case (r_state)
`ifdef JTAG_SCAN_TLR_EN
                // First cycle loads the TLR transaction, second cycle ends GO.
                ST_TLR_GO: begin
                    if (!r_proc_en) begin
                        r_proc_en  <= 1'b1;
                        r_proc_len <= 32'd6;
                        r_proc_tms <= 32'h1F;
                        r_proc_tdi <= 32'd0;
                    end else begin
                        r_proc_en <= 1'b0;
                        r_state   <= ST_TLR_WAIT;
                    end
                end
                ST_TLR_WAIT: begin
                    if (PROC_DONE) begin
                        r_state     <= ST_IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                end
`endif
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (CMD_VALID && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_ir        <= CMD_IR;
                        r_len       <= CMD_LEN;
                        r_tdi       <= CMD_TDI;
                        r_rsp_tdo   <= 64'd0;
                        if (CMD_LEN == 7'd0 || CMD_LEN > 7'd64) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_state     <= ST_RSP;
                        end else begin
                            r_proc_en  <= 1'b1;
                            r_proc_len <= CMD_IR ? 32'd4 : 32'd3;
                            r_proc_tms <= CMD_IR ? 32'h3 : 32'h1;
                            r_proc_tdi <= 32'd0;
                            r_state    <= ST_PRE_GO;
                        end
                    end
                end
                ST_PRE_GO: begin
                    r_proc_en <= 1'b0;
                    r_state   <= ST_PRE_WAIT;
                end
                ST_PRE_WAIT: begin
                    if (PROC_DONE) begin
                        r_proc_en  <= 1'b1;
                        r_proc_len <= {26'd0, w_len0};
                        r_proc_tms <= w_tms0;
                        r_proc_tdi <= r_tdi[31:0];
                        r_state    <= ST_D0_GO;
                    end
                end
                ST_D0_GO: begin
                    r_proc_en <= 1'b0;
                    r_state   <= ST_D0_WAIT;
                end
                ST_D0_WAIT: begin
                    if (PROC_DONE) begin
                        r_rsp_tdo[31:0] <= PROC_TDO & w_mask0;
                        r_proc_en       <= 1'b1;
                        if (w_has_d1) begin
                            r_proc_len <= {26'd0, w_len1};
                            r_proc_tms <= w_tms1;
                            r_proc_tdi <= r_tdi[63:32];
                            r_state    <= ST_D1_GO;
                        end else begin
                            r_proc_len <= LP_POST_LEN;
                            r_proc_tms <= 32'h1;
                            r_proc_tdi <= 32'd0;
                            r_state    <= ST_POST_GO;
                        end
                    end
                end
                ST_D1_GO: begin
                    r_proc_en <= 1'b0;
                    r_state   <= ST_D1_WAIT;
                end
                ST_D1_WAIT: begin
                    if (PROC_DONE) begin
                        r_rsp_tdo[63:32] <= PROC_TDO & w_mask1;
                        r_proc_en        <= 1'b1;
                        r_proc_len       <= LP_POST_LEN;
                        r_proc_tms       <= 32'h1;
                        r_proc_tdi       <= 32'd0;
                        r_state          <= ST_POST_GO;
                    end
                end
                ST_POST_GO: begin
                    r_proc_en <= 1'b0;
                    r_state   <= ST_POST_WAIT;
                end
                ST_POST_WAIT: begin
                    if (PROC_DONE) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (RSP_READY) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_proc_en   <= 1'b0;
                    r_cmd_ready <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign CMD_READY   = r_cmd_ready;
    assign RSP_VALID   = r_rsp_valid;
    assign RSP_ERR     = r_rsp_err;
    assign RSP_TDO     = r_rsp_tdo;
    assign PROC_ENABLE = r_proc_en;
    assign PROC_LENGTH = r_proc_len;
    assign PROC_TMS    = r_proc_tms;
    assign PROC_TDI    = r_proc_tdi;
    assign o_dbg_state = r_state;

endmodule
